core_sleep_unit: RTL and testbench
==================================

# core_sleep_unit

APB-controlled sleep/wake sequencer for one core, directly downstream of the interrupt service unit. It consumes the service unit's `irq_o` and the event unit's output, gates the core clock when software requests sleep, and re-enables it on a masked wake source. It produces `core_sleeping_o`, which feeds the service unit's `core_sleeping_i`.

## Interface
- `APB_ADDR_WIDTH`, default 12: APB address width (4 KB slave).
- `HCLK  in  1`: clock.
- `HRESET  in  1`: reset, asynchronous, active-high.
- `PADDR  in  APB_ADDR_WIDTH`: APB address; `PADDR[3:2]` selects the register.
- `PWDATA  in  32`: APB write data.
- `PWRITE  in  1`: APB write strobe.
- `PSEL  in  1`: APB select.
- `PENABLE  in  1`: APB enable.
- `PRDATA  out  32`: APB read data.
- `PREADY  out  1`: APB ready, constant 1.
- `PSLVERR  out  1`: APB error, constant 0.
- `irq_i  in  1`: from service unit `irq_o`.
- `event_i  in  1`: from event unit.
- `core_busy_i  in  1`: core has outstanding transactions.
- `core_clock_en_o  out  1`: core clock-gate enable.
- `core_sleeping_o  out  1`: to service unit `core_sleeping_i`.

## Operation
- Registers (offset, reset value):
  - 0x0 CTRL: write bit0=1 requests sleep. Read returns {30'b0, state[1:0]}.
  - 0x4 WAKE_MASK [1:0], reset 0x3: bit0 enables `irq_i`, bit1 enables `event_i`.
  - 0x8 WAKE_DELAY [7:0], reset 0x00.
  - 0xC SLEEP_CNT [31:0], read-only, reset 0.
- Reads of unmapped bits or registers return 0. Writes to SLEEP_CNT are ignored.
- `wake = |(WAKE_MASK & {event_i, irq_i})`.
- FSM states, with encodings: RUN=0, WAIT_IDLE=1, SLEEP=2, WAKE=3.
  - RUN → WAIT_IDLE on a CTRL write with bit0=1. A CTRL write in any other state is ignored.
  - WAIT_IDLE → RUN if `wake` (aborted sleep; SLEEP_CNT unchanged). Abort takes priority over idle.
  - WAIT_IDLE → SLEEP if `!wake && !core_busy_i`. SLEEP_CNT increments by 1 on this transition and wraps 0xFFFFFFFF → 0.
  - WAIT_IDLE holds otherwise.
  - SLEEP → WAKE on `wake`. The down-counter loads WAKE_DELAY on this transition.
  - WAKE → RUN when the counter is 0; otherwise the counter decrements.
- Outputs are registered decodes of the next state:
  - `core_clock_en_o = (state != SLEEP)`.
  - `core_sleeping_o = (state == SLEEP || state == WAKE)`.
- A masked-out wake source has no effect. WAKE_MASK=0 means SLEEP is left only by reset.
- Reset values of the outputs: `core_clock_en_o=1`, `core_sleeping_o=0`, `PRDATA=0`, `PREADY=1`, `PSLVERR=0`. The FSM resets to RUN and the counter to 0.

## Timing
- APB access phase: `PSEL && PENABLE`. Zero wait states. Register writes take effect at the next edge.
- `PRDATA` is combinational during the access phase and 0 otherwise.
- CTRL write sampled at edge t: state=WAIT_IDLE after t.
  - If `core_busy_i=0` and `wake=0` at edge t+1: SLEEP and `core_clock_en_o=0` after t+1.
- `wake` sampled in SLEEP at edge t: `core_clock_en_o=1` after t. WAKE lasts WAKE_DELAY+1 cycles, then RUN and `core_sleeping_o=0`.
- WAKE_DELAY written while in WAKE does not alter the running count.
- A WAKE_MASK write in the same cycle as a wake check uses the old mask.
- Reset asserted mid-operation forces RUN and `core_clock_en_o=1` immediately (asynchronously). No SLEEP_CNT update.

## Structure
- Package `core_sleep_unit_pkg` holds:
  - the state enum `sleep_state_e` (2 bits, encodings as above);
  - register offset constants `SLEEP_REG_CTRL`, `SLEEP_REG_WAKE_MASK`, `SLEEP_REG_WAKE_DELAY`, `SLEEP_REG_SLEEP_CNT`.
- Single module, no sub-modules. The clock-gate cell is instantiated outside this block.

## Test plan
- After reset: read 0x4 → 0x3, 0x8 → 0, 0xC → 0, 0x0 → 0. `core_clock_en_o=1`, `core_sleeping_o=0`.
- Write CTRL=1 with `core_busy_i=1` for 5 cycles, then 0, no wake. State holds WAIT_IDLE for 5 cycles, then SLEEP: `core_clock_en_o=0`, `core_sleeping_o=1`, SLEEP_CNT=1.
- In SLEEP with WAKE_DELAY=3, pulse `irq_i` for 1 cycle:
  - `core_clock_en_o=1` the next cycle;
  - `core_sleeping_o` stays 1 for 4 cycles, then 0; state RUN.
- WAKE_MASK=0x2, in SLEEP: `irq_i=1` leaves the state in SLEEP. Then `event_i=1` → WAKE.
- Write CTRL=1 while `event_i=1` and mask 0x3: WAIT_IDLE for 1 cycle, then RUN. SLEEP_CNT unchanged, clock never gated.
- Assert `HRESET` while in SLEEP: `core_clock_en_o=1` without waiting for an edge. SLEEP_CNT=0 and WAKE_MASK=0x3 after reset.

Source files
------------

// File: rtl/core_sleep_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_sleep_unit_pkg : state encoding and register offsets for sleep unit
// Revision: 1.0
// ---------------------------------------------------------------------------
package core_sleep_unit_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_IDLE = 2'd1,
    SLEEP     = 2'd2,
    WAKE      = 2'd3
  } sleep_state_e;

  // Word index taken from PADDR[3:2]
  localparam logic [1:0] SLEEP_REG_CTRL       = 2'd0;
  localparam logic [1:0] SLEEP_REG_WAKE_MASK  = 2'd1;
  localparam logic [1:0] SLEEP_REG_WAKE_DELAY = 2'd2;
  localparam logic [1:0] SLEEP_REG_SLEEP_CNT  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/core_sleep_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_sleep_unit_if : APB3 slave bus bundle for the sleep unit
// Revision: 1.0
// ---------------------------------------------------------------------------
interface core_sleep_unit_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface
`default_nettype wire

// File: rtl/core_sleep_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_sleep_unit : APB-controlled core sleep/wake sequencer with clock gating
// Revision: 1.0
// ---------------------------------------------------------------------------
module core_sleep_unit
  import core_sleep_unit_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic             HCLK,
  input  logic             HRESET,
  core_sleep_unit_if.slave apb,
  input  logic             irq_i,
  input  logic             event_i,
  input  logic             core_busy_i,
  output logic             core_clock_en_o,
  output logic             core_sleeping_o
);

  sleep_state_e r_state;
  sleep_state_e w_next;
  logic [1:0]   r_wake_mask;
  logic [7:0]   r_wake_delay;
  logic [31:0]  r_sleep_cnt;
  logic [7:0]   r_cnt;
  logic [7:0]   w_cnt_next;
  logic         w_cnt_inc;
  logic         r_clock_en;
  logic         r_sleeping;
  logic [31:0]  w_prdata;

  logic       w_access;
  logic       w_wr;
  logic [1:0] w_sel;
  logic       w_wake;

  assign w_access = apb.PSEL && apb.PENABLE;
  assign w_wr     = w_access && apb.PWRITE;
  assign w_sel    = apb.PADDR[3:2];
  assign w_wake   = |(r_wake_mask & {event_i, irq_i});

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_cnt_inc  = 1'b0;
    case (r_state)
      RUN: begin
        if (w_wr && (w_sel == SLEEP_REG_CTRL) && apb.PWDATA[0]) begin
          w_next = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // A pending wake aborts the request even if the core is already idle
        if (w_wake) begin
          w_next = RUN;
        end else if (!core_busy_i) begin
          w_next    = SLEEP;
          w_cnt_inc = 1'b1;
        end
      end
      SLEEP: begin
        if (w_wake) begin
          w_next     = WAKE;
          w_cnt_next = r_wake_delay;
        end
      end
      WAKE: begin
        if (r_cnt == 8'd0) begin
          w_next = RUN;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      default: w_next = RUN;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state    <= RUN;
      r_cnt      <= 8'd0;
      r_clock_en <= 1'b1;
      r_sleeping <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_clock_en <= (w_next != SLEEP);
      r_sleeping <= (w_next == SLEEP) || (w_next == WAKE);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wake_mask  <= 2'b11;
      r_wake_delay <= 8'd0;
      r_sleep_cnt  <= 32'd0;
    end else begin
      if (w_wr && (w_sel == SLEEP_REG_WAKE_MASK)) begin
        r_wake_mask <= apb.PWDATA[1:0];
      end
      if (w_wr && (w_sel == SLEEP_REG_WAKE_DELAY)) begin
        r_wake_delay <= apb.PWDATA[7:0];
      end
      if (w_cnt_inc) begin
        r_sleep_cnt <= r_sleep_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    w_prdata = 32'd0;
    if (w_access) begin
      case (w_sel)
        SLEEP_REG_CTRL:       w_prdata = {30'd0, r_state};
        SLEEP_REG_WAKE_MASK:  w_prdata = {30'd0, r_wake_mask};
        SLEEP_REG_WAKE_DELAY: w_prdata = {24'd0, r_wake_delay};
        SLEEP_REG_SLEEP_CNT:  w_prdata = r_sleep_cnt;
        default:              w_prdata = 32'd0;
      endcase
    end
  end

  assign apb.PRDATA   = w_prdata;
  assign apb.PREADY   = 1'b1;
  assign apb.PSLVERR  = 1'b0;
  assign core_clock_en_o = r_clock_en;
  assign core_sleeping_o = r_sleeping;

endmodule
`default_nettype wire

// File: tb/tb_core_sleep_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_core_sleep_unit : randomized directed bench for core_sleep_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_core_sleep_unit;

  logic HCLK;
  logic HRESET;
  logic irq_i;
  logic event_i;
  logic core_busy_i;
  logic core_clock_en_o;
  logic core_sleeping_o;

  int vectors;
  int miscompares;

  // Reference model: register contents and expected counts
  int m_cnt;
  int m_mask;
  int m_delay;

  core_sleep_unit_if #(.APB_ADDR_WIDTH(12)) bus ();

  core_sleep_unit #(.APB_ADDR_WIDTH(12)) dut (
    .HCLK            (HCLK),
    .HRESET          (HRESET),
    .apb             (bus),
    .irq_i           (irq_i),
    .event_i         (event_i),
    .core_busy_i     (core_busy_i),
    .core_clock_en_o (core_clock_en_o),
    .core_sleeping_o (core_sleeping_o)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_read(input logic [11:0] addr, output logic [31:0] data);
    bus.PADDR   = addr;
    bus.PWRITE  = 1'b0;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b1;
    #1;
    data = bus.PRDATA;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  // Occupies exactly one rising edge; returns just after the following negedge
  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    bus.PADDR   = addr;
    bus.PWDATA  = data;
    bus.PWRITE  = 1'b1;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(addr, d);
    chk(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    int n;
    int newd;
    int cycles;
    int use_irq;

    vectors     = 0;
    miscompares = 0;
    irq_i       = 1'b0;
    event_i     = 1'b0;
    core_busy_i = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    bus.PWRITE  = 1'b0;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    HRESET      = 1'b1;
    m_cnt   = 0;
    m_mask  = 3;
    m_delay = 0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;

    // Reset state
    chk("rst_clk_en", core_clock_en_o, 1);
    chk("rst_sleeping", core_sleeping_o, 0);
    chk("rst_pready", bus.PREADY, 1);
    chk("rst_pslverr", bus.PSLVERR, 0);
    chk("rst_prdata_idle", bus.PRDATA, 0);
    chk_reg("rst_mask", 12'h004, 3);
    chk_reg("rst_delay", 12'h008, 0);
    chk_reg("rst_sleep_cnt", 12'h00C, 0);
    chk_reg("rst_ctrl", 12'h000, 0);

    for (int it = 0; it < 6; it++) begin
      n       = (it == 0) ? 5 : int'($urandom_range(0, 4));
      m_delay = int'($urandom_range(0, 5));
      m_mask  = int'($urandom_range(1, 3));
      apb_write(12'h008, 32'hA5A5_0000 | m_delay);
      apb_write(12'h004, 32'hFFFF_FFFC | m_mask);
      chk_reg("delay_rb", 12'h008, m_delay);
      chk_reg("mask_rb", 12'h004, m_mask);

      core_busy_i = (n > 0);
      apb_write(12'h000, 32'h1);
      chk_reg("wait_idle", 12'h000, 1);
      chk("wait_clk_en", core_clock_en_o, 1);
      for (int k = 0; k < n; k++) begin
        @(negedge HCLK);
        chk_reg("busy_hold", 12'h000, 1);
      end
      core_busy_i = 1'b0;
      @(negedge HCLK);
      m_cnt++;
      chk_reg("sleep_state", 12'h000, 2);
      chk("sleep_clk_en", core_clock_en_o, 0);
      chk("sleep_sleeping", core_sleeping_o, 1);
      chk_reg("sleep_cnt", 12'h00C, m_cnt);

      // Masked-out source must be ignored
      if (m_mask != 3) begin
        if (m_mask == 1) event_i = 1'b1; else irq_i = 1'b1;
        repeat (2) @(negedge HCLK);
        irq_i   = 1'b0;
        event_i = 1'b0;
        chk_reg("masked_src", 12'h000, 2);
        chk("masked_clk_en", core_clock_en_o, 0);
      end

      use_irq = (m_mask == 1) ? 1 : (m_mask == 2) ? 0 : int'($urandom_range(0, 1));
      if (use_irq != 0) irq_i = 1'b1; else event_i = 1'b1;
      @(negedge HCLK);
      irq_i   = 1'b0;
      event_i = 1'b0;
      chk("wake_clk_en", core_clock_en_o, 1);
      chk("wake_sleeping", core_sleeping_o, 1);
      chk_reg("wake_state", 12'h000, 3);

      // Wake phase length is fixed by the delay latched on entry
      newd   = int'($urandom_range(0, 255));
      cycles = 1;
      for (int g = 0; g < 300 && core_sleeping_o; g++) begin
        if (g == 0 && (it % 2) == 1) apb_write(12'h008, newd);
        else @(negedge HCLK);
        if (core_sleeping_o) cycles++;
      end
      chk("wake_len", cycles, m_delay + 1);
      chk_reg("back_to_run", 12'h000, 0);
      chk("run_clk_en", core_clock_en_o, 1);
      if ((it % 2) == 1) chk_reg("delay_mid_wake", 12'h008, newd);
    end

    // Abort: wake pending while waiting for idle
    apb_write(12'h004, 32'h3);
    event_i = 1'b1;
    apb_write(12'h000, 32'h1);
    chk_reg("abort_wait", 12'h000, 1);
    chk("abort_clk_en0", core_clock_en_o, 1);
    @(negedge HCLK);
    chk_reg("abort_run", 12'h000, 0);
    chk("abort_clk_en1", core_clock_en_o, 1);
    chk("abort_sleeping", core_sleeping_o, 0);
    event_i = 1'b0;
    chk_reg("abort_cnt", 12'h00C, m_cnt);

    // Mask 0: only reset leaves SLEEP
    apb_write(12'h004, 32'hFFFF_FFFC);
    chk_reg("mask0_rb", 12'h004, 0);
    apb_write(12'h000, 32'h1);
    @(negedge HCLK);
    m_cnt++;
    chk_reg("mask0_sleep", 12'h000, 2);
    irq_i   = 1'b1;
    event_i = 1'b1;
    repeat (3) @(negedge HCLK);
    chk_reg("mask0_hold", 12'h000, 2);
    irq_i   = 1'b0;
    event_i = 1'b0;
    apb_write(12'h00C, 32'hDEAD_BEEF);
    chk_reg("cnt_ro", 12'h00C, m_cnt);
    apb_write(12'h000, 32'h1);
    chk_reg("ctrl_ignored", 12'h000, 2);
    chk("mask0_clk_en", core_clock_en_o, 0);

    // Asynchronous reset away from any clock edge
    #2;
    HRESET = 1'b1;
    #1;
    chk("async_clk_en", core_clock_en_o, 1);
    chk("async_sleeping", core_sleeping_o, 0);
    @(negedge HCLK);
    HRESET = 1'b0;
    m_cnt = 0;
    chk_reg("post_rst_cnt", 12'h00C, m_cnt);
    chk_reg("post_rst_mask", 12'h004, 3);
    chk_reg("post_rst_state", 12'h000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
